// File: rtl/controle_pkg.sv
// ============================================================================
// controle_pkg : shared constants, types and helpers for the start/stop block
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package controle_pkg;

    localparam int SYNC_STAGES = 2;

    // Width needed to count from 0 up to and including `cycles`.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

    typedef enum logic {
        CH_STOPPED = 1'b0,
        CH_RUNNING = 1'b1
    } ch_state_t;

endpackage

`default_nettype wire

// File: rtl/controle_start_stop_multi_debounce_edge.sv
// ============================================================================
// debounce_edge : synchroniser, debouncer and press (falling-edge) pulse
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module debounce_edge
    import controle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_prime;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_level_d;
    logic                   r_armed;
    logic                   r_press;
    logic                   w_synced;
    logic [CNT_W-1:0]       w_cnt_inc;

    assign w_synced  = r_sync[SYNC_STAGES-1];
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // r_armed only sets once a genuine released level has been observed after
    // the sync pipeline refilled, so a key held through reset cannot fire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync    <= '1;
            r_prime   <= '0;
            r_cnt     <= '0;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_armed   <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], btn_n};
            r_prime   <= {r_prime[SYNC_STAGES-2:0], 1'b1};
            r_level_d <= r_level;
            if (w_synced != r_level) begin
                if (w_cnt_inc == C_LIMIT) begin
                    r_level <= w_synced;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= w_cnt_inc;
                end
            end else begin
                r_cnt <= '0;
            end
            if (r_prime[SYNC_STAGES-1] && w_synced && r_level) begin
                r_armed <= 1'b1;
            end
            r_press <= r_armed & r_level_d & ~r_level;
        end
    end

    assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/controle_start_stop_multi.sv
// ============================================================================
// controle_start_stop_multi : multi-channel start/stop run-flag controller
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module controle_start_stop_multi
    import controle_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TOGGLE_MODE     = 0,
    parameter int EXCLUSIVE       = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] start_button,
    input  logic [N_CH-1:0] stop_button,
    input  logic            stop_all,
    output logic [N_CH-1:0] running,
    output logic [N_CH-1:0] started,
    output logic [N_CH-1:0] stopped
);

    logic [N_CH-1:0] w_start_press;
    logic [N_CH-1:0] w_stop_press;
    logic [N_CH-1:0] w_cur;
    logic [N_CH-1:0] w_base_next;
    logic [N_CH-1:0] w_req;
    logic [N_CH-1:0] w_grant;
    logic [N_CH-1:0] w_next;
    logic            w_found;

    ch_state_t       r_state [N_CH];
    logic [N_CH-1:0] r_started;
    logic [N_CH-1:0] r_stopped;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
                .clk   (clk),
                .rst_n (rst_n),
                .btn_n (start_button[i]),
                .press (w_start_press[i])
            );
            debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
                .clk   (clk),
                .rst_n (rst_n),
                .btn_n (stop_button[i]),
                .press (w_stop_press[i])
            );
            assign w_cur[i] = (r_state[i] == CH_RUNNING);
        end
    endgenerate

    always_comb begin
        w_base_next = '0;
        w_req       = '0;
        w_grant     = '0;
        w_next      = '0;
        w_found     = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (stop_all || w_stop_press[i]) begin
                w_base_next[i] = 1'b0;
            end else if (w_start_press[i]) begin
                w_base_next[i] = (TOGGLE_MODE != 0) ? ~w_cur[i] : 1'b1;
            end else begin
                w_base_next[i] = w_cur[i];
            end
            w_req[i] = !stop_all && !w_stop_press[i] && w_start_press[i] && w_base_next[i];
        end
        // Lowest requesting index wins the exclusive grant.
        for (int i = 0; i < N_CH; i++) begin
            if (w_req[i] && !w_found) begin
                w_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
        if ((EXCLUSIVE != 0) && w_found) begin
            w_next = w_grant;
        end else begin
            w_next = w_base_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= CH_STOPPED;
            end
            r_started <= '0;
            r_stopped <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= w_next[i] ? CH_RUNNING : CH_STOPPED;
            end
            r_started <= w_next & ~w_cur;
            r_stopped <= ~w_next & w_cur;
        end
    end

    assign running = w_cur;
    assign started = r_started;
    assign stopped = r_stopped;

endmodule

`default_nettype wire

// File: tb/tb_controle_start_stop_multi.sv
// ============================================================================
// tb_controle_start_stop_multi : directed bench for default, toggle, exclusive
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_controle_start_stop_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start_button;
    logic [1:0] stop_button;
    logic       stop_all;

    logic [1:0] run_d, sta_d, sto_d;
    logic [1:0] run_t, sta_t, sto_t;
    logic [1:0] run_x, sta_x, sto_x;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    controle_start_stop_multi #(.N_CH(2), .DEBOUNCE_CYCLES(4), .TOGGLE_MODE(0), .EXCLUSIVE(0)) dut (
        .clk(clk), .rst_n(rst_n), .start_button(start_button), .stop_button(stop_button),
        .stop_all(stop_all), .running(run_d), .started(sta_d), .stopped(sto_d)
    );

    controle_start_stop_multi #(.N_CH(2), .DEBOUNCE_CYCLES(4), .TOGGLE_MODE(1), .EXCLUSIVE(0)) dut_tog (
        .clk(clk), .rst_n(rst_n), .start_button(start_button), .stop_button(stop_button),
        .stop_all(stop_all), .running(run_t), .started(sta_t), .stopped(sto_t)
    );

    controle_start_stop_multi #(.N_CH(2), .DEBOUNCE_CYCLES(4), .TOGGLE_MODE(0), .EXCLUSIVE(1)) dut_exc (
        .clk(clk), .rst_n(rst_n), .start_button(start_button), .stop_button(stop_button),
        .stop_all(stop_all), .running(run_x), .started(sta_x), .stopped(sto_x)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        start_button = 2'b11;
        stop_button  = 2'b11;
        stop_all     = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        start_button = 2'b00;
        stop_button  = 2'b00;
        stop_all     = 1'b0;
        tick(3);
        checks++;
        if ({run_d, sta_d, sto_d, run_t, run_x} !== 10'b0) begin
            errors++;
            $display("FAIL reset_state: got %b, want 0", {run_d, sta_d, sto_d, run_t, run_x});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            checks++;
            if ({run_d, sta_d, sto_d, run_t, sta_t, sto_t, run_x, sta_x, sto_x} !== 18'b0) begin
                errors++;
                $display("FAIL held_after_reset cycle %0d: got %b, want 0", k,
                         {run_d, sta_d, sto_d, run_t, sta_t, sto_t, run_x, sta_x, sto_x});
            end
        end
        start_button = 2'b11;
        stop_button  = 2'b11;
        tick(20);
        checks++;
        if ({run_d, run_t, run_x} !== 6'b0) begin
            errors++;
            $display("FAIL release_after_reset: got %b, want 0", {run_d, run_t, run_x});
        end
        start_button = 2'b10;
        tick(7);
        checks++;
        if (run_d !== 2'b00 || sta_d !== 2'b00) begin
            errors++;
            $display("FAIL latency_early: running=%b started=%b, want 00/00", run_d, sta_d);
        end
        tick(1);
        checks++;
        if (run_d !== 2'b01 || sta_d !== 2'b01) begin
            errors++;
            $display("FAIL latency_edge: running=%b started=%b, want 01/01", run_d, sta_d);
        end
        tick(1);
        checks++;
        if (run_d !== 2'b01 || sta_d !== 2'b00) begin
            errors++;
            $display("FAIL started_width: running=%b started=%b, want 01/00", run_d, sta_d);
        end
        start_button = 2'b11;
        tick(12);
    endtask

    task automatic test_bounce();
        int pulses;
        do_reset();
        pulses = 0;
        for (int r = 0; r < 5; r++) begin
            start_button = 2'b10;
            for (int k = 0; k < 3; k++) begin tick(1); pulses += int'(sta_d[0]); end
            start_button = 2'b11;
            for (int k = 0; k < 3; k++) begin tick(1); pulses += int'(sta_d[0]); end
        end
        tick(8);
        checks++;
        if (run_d !== 2'b00 || pulses != 0) begin
            errors++;
            $display("FAIL bounce_ignored: running=%b pulses=%0d, want 00/0", run_d, pulses);
        end
        start_button = 2'b10;
        for (int k = 0; k < 10; k++) begin tick(1); pulses += int'(sta_d[0]); end
        start_button = 2'b11;
        for (int k = 0; k < 10; k++) begin tick(1); pulses += int'(sta_d[0]); end
        checks++;
        if (run_d !== 2'b01 || pulses != 1) begin
            errors++;
            $display("FAIL bounce_then_hold: running=%b pulses=%0d, want 01/1", run_d, pulses);
        end
    endtask

    task automatic test_toggle();
        logic exp;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            exp = ((k % 2) == 0);
            start_button = 2'b01;
            tick(8);
            checks++;
            if (run_t[1] !== exp || sta_t[1] !== exp || sto_t[1] !== ~exp) begin
                errors++;
                $display("FAIL toggle_press %0d: running=%b started=%b stopped=%b, want run1=%b st1=%b sp1=%b",
                         k, run_t, sta_t, sto_t, exp, exp, ~exp);
            end
            tick(1);
            checks++;
            if (sta_t !== 2'b00 || sto_t !== 2'b00) begin
                errors++;
                $display("FAIL toggle_pulse_width %0d: started=%b stopped=%b, want 00/00", k, sta_t, sto_t);
            end
            tick(3);
            start_button = 2'b11;
            tick(12);
        end
        checks++;
        if (run_d !== 2'b10) begin
            errors++;
            $display("FAIL set_mode_repeat: running=%b, want 10", run_d);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        start_button = 2'b10;
        stop_button  = 2'b10;
        tick(8);
        checks++;
        if (run_d !== 2'b00 || sta_d !== 2'b00 || sto_d !== 2'b00) begin
            errors++;
            $display("FAIL both_while_stopped: running=%b started=%b stopped=%b, want 00/00/00", run_d, sta_d, sto_d);
        end
        tick(2);
        start_button = 2'b11;
        stop_button  = 2'b11;
        tick(12);
        start_button = 2'b10;
        tick(8);
        checks++;
        if (run_d !== 2'b01 || sta_d !== 2'b01) begin
            errors++;
            $display("FAIL start_ch0: running=%b started=%b, want 01/01", run_d, sta_d);
        end
        tick(2);
        start_button = 2'b11;
        tick(12);
        start_button = 2'b10;
        stop_button  = 2'b10;
        tick(8);
        checks++;
        if (run_d !== 2'b00 || sta_d !== 2'b00 || sto_d !== 2'b01) begin
            errors++;
            $display("FAIL both_while_running: running=%b started=%b stopped=%b, want 00/00/01", run_d, sta_d, sto_d);
        end
        tick(1);
        checks++;
        if (sto_d !== 2'b00) begin
            errors++;
            $display("FAIL stopped_width: stopped=%b, want 00", sto_d);
        end
        start_button = 2'b11;
        stop_button  = 2'b11;
        tick(12);
    endtask

    task automatic test_exclusive();
        do_reset();
        start_button = 2'b01;
        tick(8);
        checks++;
        if (run_x !== 2'b10 || sta_x !== 2'b10) begin
            errors++;
            $display("FAIL excl_start_ch1: running=%b started=%b, want 10/10", run_x, sta_x);
        end
        tick(2);
        start_button = 2'b11;
        tick(12);
        start_button = 2'b00;
        tick(8);
        checks++;
        if (run_x !== 2'b01 || sta_x !== 2'b01 || sto_x !== 2'b10) begin
            errors++;
            $display("FAIL excl_grant: running=%b started=%b stopped=%b, want 01/01/10", run_x, sta_x, sto_x);
        end
        checks++;
        if (run_d !== 2'b11 || sta_d !== 2'b01 || sto_d !== 2'b00) begin
            errors++;
            $display("FAIL nonexcl_both: running=%b started=%b stopped=%b, want 11/01/00", run_d, sta_d, sto_d);
        end
        checks++;
        if (run_t !== 2'b01 || sta_t !== 2'b01 || sto_t !== 2'b10) begin
            errors++;
            $display("FAIL toggle_both: running=%b started=%b stopped=%b, want 01/01/10", run_t, sta_t, sto_t);
        end
        tick(1);
        checks++;
        if (run_x !== 2'b01 || sta_x !== 2'b00 || sto_x !== 2'b00) begin
            errors++;
            $display("FAIL excl_after: running=%b started=%b stopped=%b, want 01/00/00", run_x, sta_x, sto_x);
        end
        start_button = 2'b11;
        tick(12);
    endtask

    task automatic test_stop_all();
        do_reset();
        start_button = 2'b00;
        tick(8);
        checks++;
        if (run_d !== 2'b11) begin
            errors++;
            $display("FAIL both_started: running=%b, want 11", run_d);
        end
        tick(2);
        start_button = 2'b11;
        tick(12);
        stop_all = 1'b1;
        tick(1);
        stop_all = 1'b0;
        checks++;
        if (run_d !== 2'b00 || sto_d !== 2'b11 || sta_d !== 2'b00) begin
            errors++;
            $display("FAIL stop_all: running=%b started=%b stopped=%b, want 00/00/11", run_d, sta_d, sto_d);
        end
        checks++;
        if (run_x !== 2'b00 || sto_x !== 2'b01) begin
            errors++;
            $display("FAIL stop_all_excl: running=%b stopped=%b, want 00/01", run_x, sto_x);
        end
        tick(1);
        checks++;
        if (sto_d !== 2'b00) begin
            errors++;
            $display("FAIL stop_all_width: stopped=%b, want 00", sto_d);
        end
        start_button = 2'b10;
        tick(7);
        stop_all = 1'b1;
        tick(1);
        stop_all = 1'b0;
        checks++;
        if (run_d !== 2'b00 || sta_d !== 2'b00) begin
            errors++;
            $display("FAIL start_vs_stop_all: running=%b started=%b, want 00/00", run_d, sta_d);
        end
        tick(5);
        checks++;
        if (run_d !== 2'b00) begin
            errors++;
            $display("FAIL start_vs_stop_all_hold: running=%b, want 00", run_d);
        end
        start_button = 2'b11;
        tick(12);
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_toggle();
        test_simultaneous();
        test_exclusive();
        test_stop_all();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
